lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//   Load/store sequencer between the execute stage and the synchronous, byte-enabled 4 KB data memory.
//   Accepts one RV32I load/store per handshake and decodes funct3 into byte enables and lane-replicated write data.
//   Drives the memory strobes for the required cycles, then returns sign/zero-extended load data.
//   Flags misaligned, out-of-range and illegal-funct3 accesses as faults without touching memory.
// PARAMETERS
//   MEM_BYTES   4096  size of data memory in bytes; any addr >= MEM_BYTES is a range fault
//   CHECK_RANGE 1     1: enforce the MEM_BYTES check; 0: no range check, upper address bits ignored
// PORTS
//   clk             in   1   clock; all state updates on rising edge
//   rst             in   1   synchronous active-high reset
//   req_valid       in   1   request present
//   req_ready       out  1   controller can accept a request this cycle
//   req_we          in   1   1 = store, 0 = load
//   req_funct3      in   3   RV32I funct3: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
//   req_addr        in   32  byte address
//   req_wdata       in   32  store data, right-justified
//   rsp_valid       out  1   response present; held until rsp_ready
//   rsp_ready       in   1   consumer accepts response
//   rsp_rdata       out  32  extended load data; 0 for stores and faults
//   rsp_fault       out  2   00 ok, 01 misaligned, 10 out of range, 11 illegal funct3
//   mem_addr        out  32  word address to memory: {req_addr[31:2],2'b00} of the latched request
//   mem_write_data  out  32  lane-replicated store data
//   mem_byte_enable out  4   per-byte write enable
//   mem_write       out  1   write strobe
//   mem_read        out  1   read strobe
//   mem_read_data   in   32  memory read data; valid the cycle after an edge sampled with mem_read=1
// BEHAVIOUR
//   States: IDLE, ACCESS, RESP. Request fields are latched on accept (req_valid && req_ready).
//   req_ready = (state==IDLE) && !rst. No request is accepted outside IDLE.
//   IDLE -> ACCESS: accept, no fault. IDLE -> RESP: accept, with fault; memory is not touched.
//   ACCESS -> RESP: always, after 1 cycle.
//   RESP -> IDLE: when rsp_ready=1. rsp_valid=1 only in RESP.
//   Fault priority: illegal > range > misaligned.
//     Illegal: load funct3 in {011,110,111}; store funct3[2]=1 or funct3=011.
//     Misaligned: half with addr[0]=1; word with addr[1:0]!=0. Byte accesses are never misaligned.
//   Store, ACCESS cycle: mem_write=1 for exactly one cycle.
//     byte_enable: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
//     write_data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
//   Load: mem_read=1 in ACCESS and in every RESP cycle. This keeps memory output valid through back-pressure.
//     mem_write=0 and byte_enable=0 for loads.
//   rsp_rdata in RESP (load, no fault): lane select by latched addr[1:0].
//     LB/LBU sign/zero-extend byte addr[1:0]; LH/LHU extend half addr[1]; LW passes the full word.
//   Latency, no back-pressure: accept at edge N, rsp_valid high after edge N+2. Faults: after edge N+1.
//   Back-to-back: next request can be accepted the cycle after the rsp handshake (req_ready rises then).
//   Outside the cycles above, all mem_* outputs are 0. mem_addr and mem_write_data hold the latched values.
//   mem_read and mem_write are forced 0 combinationally while rst=1, so a reset in ACCESS aborts with no write.
//   Reset values: state IDLE, latched request 0, rsp_valid 0, rsp_rdata 0, rsp_fault 00, all mem_* outputs 0.
//   A reset asserted in RESP drops the pending response; no response is ever issued for it.
// TESTING
//   SW addr 0x10, wdata 0xDEADBEEF, then LW 0x10 -> rsp_rdata 0xDEADBEEF, fault 00.
//     Check: one-cycle mem_write with byte_enable 1111; rsp_valid 2 edges after accept.
//   SB 0x13, wdata 0x80 over 0x11223344 -> byte_enable 1000, mem_write_data 0x80808080.
//     Then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080.
//   LH 0x12 with word 0x8001_7FFF -> 0xFFFF8001.
//     Then LH 0x11 -> fault 01, no mem_read/mem_write pulse, rsp after 1 edge.
//   LW 0x1000 with CHECK_RANGE=1 -> fault 10. Load funct3=110 -> fault 11. Store funct3=100 -> fault 11.
//   Hold rsp_ready=0 for 5 cycles on LW 0x10 -> rsp_rdata stable, mem_read held 1, req_ready 0 throughout.
//   Assert rst during ACCESS of SW 0x20 -> mem_write never sampled high, word 0x20 unchanged.
//     Then state IDLE and rsp_valid=0 after the reset edge.

Source files
------------

// File: rtl/lsu_if.sv
// Bundle of the execute-stage request/response handshake and the data-memory
// strobe bus seen by the load/store sequencer.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  rsp_ready, mem_read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault,
        output mem_addr, mem_write_data, mem_byte_enable, mem_write, mem_read
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output rsp_ready, mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
        input  mem_addr, mem_write_data, mem_byte_enable, mem_write, mem_read
    );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32I load/store sequencer: decodes funct3 into byte lanes, strobes the
// synchronous data memory, and returns extended load data or a fault code.
module lsu_ctrl #(
    parameter int unsigned MEM_BYTES   = 4096,
    parameter bit          CHECK_RANGE = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE   = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b11;

    state_t state_reg, state_next;

    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  fault_reg;

    logic        accept;
    logic        illegal;
    logic        out_of_range;
    logic        misaligned;
    logic [1:0]  fault_dec;

    logic [3:0]       be_lanes;
    logic [3:0][7:0]  wr_lanes;
    logic [3:0][7:0]  rd_lanes;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic [31:0]      load_data;

    assign accept = bus.req_valid && (state_reg == IDLE) && !rst;

    // Request decode: evaluated on the incoming fields so the fault is known at accept.
    always_comb begin
        if (bus.req_we) begin
            illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
        end else begin
            illegal = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110);
        end

        out_of_range = CHECK_RANGE && (bus.req_addr >= 32'(MEM_BYTES));

        case (bus.req_funct3[1:0])
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        if (illegal) begin
            fault_dec = FAULT_ILLEGAL;
        end else if (out_of_range) begin
            fault_dec = FAULT_RANGE;
        end else if (misaligned) begin
            fault_dec = FAULT_MISALIGN;
        end else begin
            fault_dec = FAULT_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= 32'd0;
            wdata_reg  <= 32'd0;
            fault_reg  <= FAULT_NONE;
        end else if (accept) begin
            we_reg     <= bus.req_we;
            funct3_reg <= bus.req_funct3;
            addr_reg   <= bus.req_addr;
            wdata_reg  <= bus.req_wdata;
            fault_reg  <= fault_dec;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (fault_dec == FAULT_NONE) ? ACCESS : RESP;
                end
            end
            ACCESS: state_next = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-lane store enables and replicated store data from the latched request.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);

            assign be_lanes[gi] = (funct3_reg[1:0] == 2'b00) ? (addr_reg[1:0] == LANE) :
                                  (funct3_reg[1:0] == 2'b01) ? (addr_reg[1] == LANE[1]) :
                                  1'b1;

            assign wr_lanes[gi] = (funct3_reg[1:0] == 2'b00) ? wdata_reg[7:0] :
                                  (funct3_reg[1:0] == 2'b01) ? wdata_reg[8*(gi%2) +: 8] :
                                  wdata_reg[8*gi +: 8];
        end
    endgenerate

    assign rd_lanes = bus.mem_read_data;

    always_comb begin
        sel_byte = rd_lanes[addr_reg[1:0]];
        sel_half = addr_reg[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
        case (funct3_reg)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_data = {24'd0, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_data = {16'd0, sel_half};
            3'b010:  load_data = bus.mem_read_data;
            default: load_data = 32'd0;
        endcase
    end

    // Output logic. Strobes are gated by rst so a reset mid-access never writes.
    always_comb begin
        bus.req_ready       = (state_reg == IDLE) && !rst;
        bus.rsp_valid       = (state_reg == RESP) && !rst;
        bus.rsp_fault       = (state_reg == RESP) ? fault_reg : FAULT_NONE;
        bus.rsp_rdata       = ((state_reg == RESP) && !we_reg && (fault_reg == FAULT_NONE))
                              ? load_data : 32'd0;
        bus.mem_addr        = {addr_reg[31:2], 2'b00};
        bus.mem_write_data  = wr_lanes;
        bus.mem_byte_enable = ((state_reg == ACCESS) && we_reg) ? be_lanes : 4'b0000;
        bus.mem_write       = (state_reg == ACCESS) && we_reg && !rst;
        // Loads keep reading through RESP so the memory output survives back-pressure.
        bus.mem_read        = !rst && !we_reg &&
                              ((state_reg == ACCESS) ||
                               ((state_reg == RESP) && (fault_reg == FAULT_NONE)));
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array memory model plus directed and random
// load/store transactions checked against a byte-level reference.
module tb_lsu_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   mem_clear = 1'b1;

    lsu_if bus();

    lsu_ctrl #(.MEM_BYTES(4096), .CHECK_RANGE(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous byte-enabled memory attached to the DUT
    logic [31:0] dmem [0:1023];
    int unsigned wr_edges = 0;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= 32'd0;
        end else if (bus.mem_write) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_byte_enable[b]) dmem[bus.mem_addr[11:2]][8*b +: 8] <= bus.mem_write_data[8*b +: 8];
        end
        if (bus.mem_write) wr_edges <= wr_edges + 1;
        if (bus.mem_read) bus.mem_read_data <= dmem[bus.mem_addr[11:2]];
    end

    // Reference: flat byte memory and RV32I rules
    logic [7:0] ref_mem [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] obs_rdata, obs_be_wd, obs_wd;
    logic [3:0]  obs_be;
    logic [1:0]  obs_fault;
    int          obs_edges, obs_wr, obs_rd;
    bit          obs_timeout, obs_hold_ok;

    logic [1:0]  e_flt;
    logic [31:0] e_rd, e_wd;
    logic [3:0]  e_be;

    task automatic ref_apply(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
        int size;
        bit legal;
        longint unsigned v;
        e_flt = 2'b00; e_rd = 32'd0; e_be = 4'd0; e_wd = 32'd0;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        size = 1 << f3[1:0];
        if (!legal)               e_flt = 2'b11;
        else if (a >= 32'd4096)   e_flt = 2'b10;
        else if (a % size != 0)   e_flt = 2'b01;
        for (int l = 0; l < 4; l++) e_wd[8*l +: 8] = 8'(wd >> (8 * (l % size)));
        if (e_flt != 2'b00) return;
        if (we) begin
            for (int i = 0; i < size; i++) begin
                ref_mem[a + i]   = 8'(wd >> (8 * i));
                e_be[(a % 4) + i] = 1'b1;
            end
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v = v | (longint'(ref_mem[a + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v - (64'd1 << (8 * size));
            e_rd = v[31:0];
        end
    endtask

    // Drives one request, observes memory strobes and the response; hold = cycles of rsp back-pressure
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int hold);
        bit got;
        obs_rdata = 0; obs_fault = 0; obs_edges = 0; obs_wr = 0; obs_rd = 0;
        obs_be = 0; obs_wd = 0; obs_timeout = 0; obs_hold_ok = 1; got = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
        if (!bus.req_ready) begin
            obs_timeout = 1; bus.req_valid = 1'b0; return;
        end
        @(posedge clk);
        obs_edges = 1;
        #1 bus.req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_write) begin
                obs_wr++; obs_be = bus.mem_byte_enable; obs_wd = bus.mem_write_data;
            end
            if (bus.mem_read) obs_rd++;
            if (bus.rsp_valid) begin got = 1; break; end
            @(posedge clk);
            obs_edges++;
        end
        if (!got) begin obs_timeout = 1; return; end
        obs_rdata = bus.rsp_rdata;
        obs_fault = bus.rsp_fault;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.rsp_rdata !== obs_rdata || bus.mem_read !== 1'b1 ||
                bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1) obs_hold_ok = 0;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        $display("txn we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h fault=%0d edges=%0d wr=%0d be=%b",
                 we, f3, a, wd, obs_rdata, obs_fault, obs_edges, obs_wr, obs_be);
    endtask

    task automatic test_reset;
        bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0;
        bus.req_wdata = 0; bus.rsp_ready = 0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
        rst = 1'b1; mem_clear = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_active: ready=%b rd=%b wr=%b, required 0 0 0",
                     bus.req_ready, bus.mem_read, bus.mem_write);
        end
        rst = 1'b0; mem_clear = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_fault !== 2'b00 ||
            bus.rsp_rdata !== 32'd0 || bus.mem_byte_enable !== 4'd0 || bus.mem_addr !== 32'd0 ||
            bus.mem_write_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values: ready=%b rsp_valid=%b fault=%b rdata=%h be=%b addr=%h wd=%h",
                     bus.req_ready, bus.rsp_valid, bus.rsp_fault, bus.rsp_rdata,
                     bus.mem_byte_enable, bus.mem_addr, bus.mem_write_data);
        end
    endtask

    task automatic test_word;
        ref_apply(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        run_txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        n_checks++;
        if (obs_timeout || obs_wr != 1 || obs_be !== 4'b1111 || obs_wd !== 32'hDEADBEEF || obs_edges != 2) begin
            n_fail++;
            $display("FAIL sw_word: to=%0d wr=%0d be=%b wd=%h edges=%0d, required 0 1 1111 deadbeef 2",
                     obs_timeout, obs_wr, obs_be, obs_wd, obs_edges);
        end
        ref_apply(1'b0, 3'd2, 32'h10, 32'd0);
        run_txn(1'b0, 3'd2, 32'h10, 32'd0, 0);
        n_checks++;
        if (obs_timeout || obs_rdata !== 32'hDEADBEEF || obs_fault !== 2'b00 || obs_edges != 2 || obs_wr != 0) begin
            n_fail++;
            $display("FAIL lw_word: to=%0d rdata=%h fault=%b edges=%0d wr=%0d, required deadbeef 00 2 0",
                     obs_timeout, obs_rdata, obs_fault, obs_edges, obs_wr);
        end
    endtask

    task automatic test_sub_word;
        ref_apply(1'b1, 3'd2, 32'h10, 32'h11223344);
        run_txn(1'b1, 3'd2, 32'h10, 32'h11223344, 0);
        ref_apply(1'b1, 3'd0, 32'h13, 32'h00000080);
        run_txn(1'b1, 3'd0, 32'h13, 32'h00000080, 0);
        n_checks++;
        if (obs_wr != 1 || obs_be !== 4'b1000 || obs_wd !== 32'h80808080) begin
            n_fail++;
            $display("FAIL sb_lane: wr=%0d be=%b wd=%h, required 1 1000 80808080", obs_wr, obs_be, obs_wd);
        end
        ref_apply(1'b0, 3'd0, 32'h13, 32'd0);
        run_txn(1'b0, 3'd0, 32'h13, 32'd0, 0);
        n_checks++;
        if (obs_rdata !== 32'hFFFFFF80) begin
            n_fail++; $display("FAIL lb_sign: got %h, required ffffff80", obs_rdata);
        end
        ref_apply(1'b0, 3'd4, 32'h13, 32'd0);
        run_txn(1'b0, 3'd4, 32'h13, 32'd0, 0);
        n_checks++;
        if (obs_rdata !== 32'h00000080) begin
            n_fail++; $display("FAIL lbu_zero: got %h, required 00000080", obs_rdata);
        end
        ref_apply(1'b1, 3'd2, 32'h10, 32'h80017FFF);
        run_txn(1'b1, 3'd2, 32'h10, 32'h80017FFF, 0);
        ref_apply(1'b0, 3'd1, 32'h12, 32'd0);
        run_txn(1'b0, 3'd1, 32'h12, 32'd0, 0);
        n_checks++;
        if (obs_rdata !== 32'hFFFF8001) begin
            n_fail++; $display("FAIL lh_sign: got %h, required ffff8001", obs_rdata);
        end
        ref_apply(1'b0, 3'd5, 32'h10, 32'd0);
        run_txn(1'b0, 3'd5, 32'h10, 32'd0, 0);
        n_checks++;
        if (obs_rdata !== 32'h00007FFF) begin
            n_fail++; $display("FAIL lhu_zero: got %h, required 00007fff", obs_rdata);
        end
        ref_apply(1'b1, 3'd1, 32'h12, 32'h0000A5C3);
        run_txn(1'b1, 3'd1, 32'h12, 32'h0000A5C3, 0);
        n_checks++;
        if (obs_wr != 1 || obs_be !== 4'b1100 || obs_wd !== 32'hA5C3A5C3) begin
            n_fail++;
            $display("FAIL sh_lane: wr=%0d be=%b wd=%h, required 1 1100 a5c3a5c3", obs_wr, obs_be, obs_wd);
        end
    endtask

    task automatic test_faults;
        logic        t_we  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  t_f3  [8] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd6, 3'd2, 3'd2, 3'd4};
        logic [31:0] t_adr [8] = '{32'h11, 32'h1000, 32'h10, 32'h1001, 32'h10, 32'h1001, 32'h12, 32'h13};
        logic [1:0]  t_exp [8] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
        for (int i = 0; i < 8; i++) begin
            ref_apply(t_we[i], t_f3[i], t_adr[i], 32'h5A5A5A5A);
            run_txn(t_we[i], t_f3[i], t_adr[i], 32'h5A5A5A5A, 0);
            n_checks++;
            if (obs_timeout || obs_fault !== t_exp[i] || obs_edges != ((t_exp[i] != 2'b00) ? 1 : 2) ||
                obs_wr != 0 || ((t_exp[i] != 2'b00) && (obs_rd != 0 || obs_rdata !== 32'd0))) begin
                n_fail++;
                $display("FAIL fault_case%0d: to=%0d fault=%b edges=%0d wr=%0d rd=%0d rdata=%h, required fault %b",
                         i, obs_timeout, obs_fault, obs_edges, obs_wr, obs_rd, obs_rdata, t_exp[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        ref_apply(1'b0, 3'd2, 32'h10, 32'd0);
        run_txn(1'b0, 3'd2, 32'h10, 32'd0, 5);
        n_checks++;
        if (obs_timeout || !obs_hold_ok || obs_rdata !== e_rd) begin
            n_fail++;
            $display("FAIL backpressure: to=%0d hold_ok=%0d rdata=%h, required hold_ok 1 rdata %h",
                     obs_timeout, obs_hold_ok, obs_rdata, e_rd);
        end
    endtask

    task automatic test_reset_in_access;
        int unsigned wr_before;
        ref_apply(1'b1, 3'd2, 32'h20, 32'hCAFEF00D);
        run_txn(1'b1, 3'd2, 32'h20, 32'hCAFEF00D, 0);
        wr_before = wr_edges;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h20; bus.req_wdata = 32'h12345678;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_write !== 1'b0) begin
            n_fail++; $display("FAIL rst_gates_write: mem_write=%b, required 0", bus.mem_write);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || wr_edges != wr_before ||
            dmem[8] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL rst_abort: rsp_valid=%b ready=%b writes=%0d/%0d word=%h, required 0 1 no write cafef00d",
                     bus.rsp_valid, bus.req_ready, wr_edges, wr_before, dmem[8]);
        end
        $display("txn aborted SW addr=00000020 by reset");
        ref_apply(1'b0, 3'd2, 32'h20, 32'd0);
        run_txn(1'b0, 3'd2, 32'h20, 32'd0, 0);
        n_checks++;
        if (obs_rdata !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL rst_word_kept: got %h, required cafef00d", obs_rdata);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            ref_apply(1'b0, 3'd2, 32'h10, 32'd0);
            run_txn(1'b0, 3'd2, 32'h10, 32'd0, 0);
            n_checks++;
            if (bus.req_ready !== 1'b1 || obs_rdata !== e_rd) begin
                n_fail++;
                $display("FAIL back_to_back%0d: ready=%b rdata=%h, required 1 %h", i, bus.req_ready, obs_rdata, e_rd);
            end
        end
    endtask

    task automatic test_random;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 63));
            else                           a = 32'h40 + 32'($urandom_range(0, 63));
            wd = $urandom;
            ref_apply(we, f3, a, wd);
            run_txn(we, f3, a, wd, 0);
            n_checks++;
            if (obs_timeout || obs_fault !== e_flt || obs_rdata !== e_rd ||
                obs_edges != ((e_flt != 2'b00) ? 1 : 2) ||
                obs_wr != ((we && e_flt == 2'b00) ? 1 : 0) ||
                (we && e_flt == 2'b00 && (obs_be !== e_be || obs_wd !== e_wd))) begin
                n_fail++;
                $display("FAIL random%0d: to=%0d fault=%b rdata=%h edges=%0d wr=%0d be=%b wd=%h, required fault=%b rdata=%h be=%b wd=%h",
                         i, obs_timeout, obs_fault, obs_rdata, obs_edges, obs_wr, obs_be, obs_wd,
                         e_flt, e_rd, e_be, e_wd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_sub_word();
        test_faults();
        test_backpressure();
        test_reset_in_access();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
